// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IDLE/DECODE/EXEC/WB controller for a MIPS subset; every output is registered.
// Define CTRL_SGT_EN to decode R-type funct 0x2B as set-greater-than (alu_op 1000).
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [4:0]  rr1,
   output logic [4:0]  rr2,
   output logic [4:0]  wr,
   output logic        we,
   output logic [3:0]  alu_op,
   output logic [4:0]  shift_count,
   output logic        wd_sel,
   output logic [31:0] wd,
   output logic        done,
   output logic        illegal
);

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

   typedef struct packed {
      logic        legal;
      logic [4:0]  rr1;
      logic [4:0]  rr2;
      logic [3:0]  alu;
      logic [4:0]  sh;
      logic [4:0]  wr;
      logic        wd_sel;
      logic [31:0] wd;
   } dec_t;

   state_t      state_q;
   logic [31:0] instr_q;
   logic        ready_q;
   logic [4:0]  rr1_q;
   logic [4:0]  rr2_q;
   logic [4:0]  wr_q;
   logic        we_q;
   logic [3:0]  alu_q;
   logic [4:0]  sh_q;
   logic        wd_sel_q;
   logic [31:0] wd_q;
   logic        done_q;
   logic        illegal_q;

   logic [31:0] dec_src_d;
   dec_t        dec_d;
   logic        xfer_d;

   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d = '0;
      if (w[31:26] == 6'h00) begin
         d.legal  = 1'b1;
         d.rr1    = w[25:21];
         d.rr2    = w[20:16];
         d.wr     = w[15:11];
         d.wd_sel = 1'b1;
         case (w[5:0])
            6'h20: d.alu = 4'b0010;
            6'h22: d.alu = 4'b0110;
            6'h24: d.alu = 4'b0000;
            6'h25: d.alu = 4'b0001;
            6'h27: d.alu = 4'b1100;
            6'h2A: d.alu = 4'b0111;
`ifdef CTRL_SGT_EN
            6'h2B: d.alu = 4'b1000;
`endif
            6'h00: begin
               // sll shifts the second operand; the first read port is unused
               d.alu = 4'b1110;
               d.rr1 = 5'd0;
               d.sh  = w[10:6];
            end
            6'h02: begin
               d.alu = 4'b1101;
               d.rr1 = w[20:16];
               d.rr2 = 5'd0;
               d.sh  = w[10:6];
            end
            6'h03: begin
               d.alu = 4'b1111;
               d.rr1 = w[20:16];
               d.rr2 = 5'd0;
               d.sh  = w[10:6];
            end
            default: d.legal = 1'b0;
         endcase
      end else if (w[31:26] == 6'h0F) begin
         d.legal  = 1'b1;
         d.alu    = 4'b0010;
         d.wr     = w[20:16];
         d.wd_sel = 1'b0;
         d.wd     = {w[15:0], 16'h0000};
      end
      if (!d.legal) begin
         d = '0;
      end
      return d;
   endfunction

   // One decoder serves both the incoming word (read addresses at transfer) and the held word.
   always_comb begin
      dec_src_d = (state_q == IDLE) ? instr : instr_q;
      dec_d     = decode(dec_src_d);
      xfer_d    = (state_q == IDLE) && instr_valid && ready_q;
   end

   always_ff @(posedge clk) begin
      if (xfer_d) begin
         instr_q <= instr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         rr1_q     <= 5'd0;
         rr2_q     <= 5'd0;
         wr_q      <= 5'd0;
         we_q      <= 1'b0;
         alu_q     <= 4'd0;
         sh_q      <= 5'd0;
         wd_sel_q  <= 1'b0;
         wd_q      <= 32'd0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         we_q      <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (xfer_d) begin
                  ready_q <= 1'b0;
                  rr1_q   <= dec_d.rr1;
                  rr2_q   <= dec_d.rr2;
                  state_q <= DECODE;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            DECODE: begin
               if (dec_d.legal) begin
                  alu_q   <= dec_d.alu;
                  sh_q    <= dec_d.sh;
                  state_q <= EXEC;
               end else begin
                  rr1_q     <= 5'd0;
                  rr2_q     <= 5'd0;
                  illegal_q <= 1'b1;
                  ready_q   <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            EXEC: begin
               // read addresses and ALU controls stay put through WB so the write data is stable
               wr_q     <= dec_d.wr;
               wd_sel_q <= dec_d.wd_sel;
               wd_q     <= dec_d.wd;
               we_q     <= (dec_d.wr != 5'd0);
               done_q   <= 1'b1;
               state_q  <= WB;
            end
            WB: begin
               rr1_q    <= 5'd0;
               rr2_q    <= 5'd0;
               wr_q     <= 5'd0;
               alu_q    <= 4'd0;
               sh_q     <= 5'd0;
               wd_sel_q <= 1'b0;
               wd_q     <= 32'd0;
               ready_q  <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign instr_ready = ready_q;
   assign rr1         = rr1_q;
   assign rr2         = rr2_q;
   assign wr          = wr_q;
   assign we          = we_q;
   assign alu_op      = alu_q;
   assign shift_count = sh_q;
   assign wd_sel      = wd_sel_q;
   assign wd          = wd_q;
   assign done        = done_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: spec-level decode model, register-file/ALU model, random traffic.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [4:0]  rr1, rr2, wr, shift_count;
   logic        we, wd_sel, done, illegal;
   logic [3:0]  alu_op;
   logic [31:0] wd;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .rr1(rr1), .rr2(rr2), .wr(wr), .we(we),
      .alu_op(alu_op), .shift_count(shift_count), .wd_sel(wd_sel), .wd(wd),
      .done(done), .illegal(illegal)
   );

   typedef struct {
      bit        legal;
      bit [4:0]  rr1, rr2;
      bit [3:0]  alu;
      bit [4:0]  sh;
      bit [4:0]  wr;
      bit        we;
      bit        wd_sel;
      bit [31:0] wd;
      int        xfer;
   } exp_t;

   typedef struct packed {
      logic       ready;
      logic [4:0] rr1;
      logic [4:0] rr2;
      logic [3:0] alu;
      logic [4:0] sh;
   } snap_t;

   exp_t        sb_q[$];
   int          done_cyc[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [31:0] regs [32];
   bit   [3:0]  rfun [bit [5:0]];
   logic [5:0]  rfl [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected controller response derived straight from the instruction-set table.
   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      bit [5:0] op, fn;
      e = '{default: 0};
      op = w[31:26];
      fn = w[5:0];
      if (op == 6'h00 && rfun.exists(fn)) begin
         e.legal = 1; e.alu = rfun[fn]; e.wr = w[15:11]; e.wd_sel = 1;
         if (fn == 6'h00) begin
            e.rr2 = w[20:16]; e.sh = w[10:6];
         end else if (fn == 6'h02 || fn == 6'h03) begin
            e.rr1 = w[20:16]; e.sh = w[10:6];
         end else begin
            e.rr1 = w[25:21]; e.rr2 = w[20:16];
         end
      end else if (op == 6'h0F) begin
         e.legal = 1; e.alu = 4'b0010; e.wr = w[20:16]; e.wd = {w[15:0], 16'h0000};
      end
      e.we = e.legal && (e.wr != 5'd0);
      return e;
   endfunction

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
      case (op)
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b1100: return ~(a | b);
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1000: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
         4'b1110: return b << sh;
         4'b1101: return a >> sh;
         4'b1111: return $signed(a) >>> sh;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] rd_reg(input logic [4:0] i);
      return (i == 5'd0) ? 32'd0 : regs[i];
   endfunction

   function automatic logic [31:0] rand_legal();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 4) == 0) begin
         w[31:26] = 6'h0F;
      end else begin
         w[31:26] = 6'h00;
         w[5:0]   = rfl[$urandom_range(0, 8)];
      end
      return w;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 7))
         0, 1, 2: w = rand_legal();
         3: w[31:26] = 6'h0F;
         4: begin w[31:26] = 6'h00; w[5:0] = 6'h2B; end
         5: w[31:26] = 6'h00;
         default: ;
      endcase
      return w;
   endfunction

   // Monitor: history of the two previous cycles gives the DECODE and EXEC views at retire.
   snap_t cur, h1, h2;
   exp_t  me;
   logic [31:0] wval;
   always @(negedge clk) begin
      cur = {instr_ready, rr1, rr2, alu_op, shift_count};
      if (rst_n && (done || illegal)) begin
         chk("sb_nonempty", 32'(sb_q.size() > 0), 1);
         if (sb_q.size() > 0) begin
            me = sb_q.pop_front();
            chk("event_kind", {30'd0, done, illegal}, me.legal ? 32'd2 : 32'd1);
            chk("we", 32'(we), 32'(me.we));
            if (me.legal) begin
               chk("wb_latency", 32'(cyc - me.xfer), 2);
               chk("dec_ready", 32'(h2.ready), 0);
               chk("dec_rr1", 32'(h2.rr1), 32'(me.rr1));
               chk("dec_rr2", 32'(h2.rr2), 32'(me.rr2));
               chk("exec_rr1", 32'(h1.rr1), 32'(me.rr1));
               chk("exec_rr2", 32'(h1.rr2), 32'(me.rr2));
               chk("exec_alu_op", 32'(h1.alu), 32'(me.alu));
               chk("exec_shift", 32'(h1.sh), 32'(me.sh));
               chk("wb_wr", 32'(wr), 32'(me.wr));
               chk("wb_wd_sel", 32'(wd_sel), 32'(me.wd_sel));
               chk("wb_wd", wd, me.wd);
               done_cyc.push_back(cyc);
               if (we) begin
                  wval = wd_sel ? alu_f(h1.alu, rd_reg(h1.rr1), rd_reg(h1.rr2), h1.sh) : wd;
                  regs[wr] = wval;
               end
            end else begin
               chk("illegal_latency", 32'(cyc - me.xfer), 1);
               chk("illegal_ready", 32'(instr_ready), 1);
            end
         end
      end
      h2 = h1;
      h1 = cur;
   end

   task automatic issue(input logic [31:0] w);
      int   n;
      exp_t e;
      n = 0;
      while (!instr_ready && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) begin
         checks++; errors++;
         $display("FAIL issue_timeout: instr_ready low for %0d cycles, expected high", n);
      end
      instr = w;
      instr_valid = 1'b1;
      e = model(w);
      e.xfer = cyc + 1;
      sb_q.push_back(e);
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || !instr_ready) && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) begin
         checks++; errors++;
         $display("FAIL idle_timeout: pending=%0d ready=%0b, expected 0 and 1", sb_q.size(), instr_ready);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rfun[6'h20] = 4'b0010; rfun[6'h22] = 4'b0110; rfun[6'h24] = 4'b0000;
      rfun[6'h25] = 4'b0001; rfun[6'h27] = 4'b1100; rfun[6'h2A] = 4'b0111;
      rfun[6'h00] = 4'b1110; rfun[6'h02] = 4'b1101; rfun[6'h03] = 4'b1111;
`ifdef CTRL_SGT_EN
      rfun[6'h2B] = 4'b1000;
`endif
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      regs[1] = 32'd1; regs[2] = 32'd2; regs[4] = 32'hFFFF_FFF0;

      // Reset with a valid instruction offered: must be ignored, outputs all zero.
      instr = 32'h0022_1820;
      instr_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {instr_ready, rr1, rr2, wr, we, alu_op, shift_count, wd_sel, done, illegal}, 0);
      chk("rst_wd", wd, 0);
      @(negedge clk);
      instr_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release", 32'(instr_ready), 1);

      issue(32'h0022_1820); wait_idle(); chk("reg3_add", regs[3], 32'd3);
      issue(32'h0002_2880); wait_idle(); chk("reg5_sll", regs[5], 32'd8);
      issue(32'h0004_30C3); wait_idle(); chk("reg6_sra", regs[6], 32'hFFFF_FFFE);
      issue(32'h3C07_1234); wait_idle(); chk("reg7_lui", regs[7], 32'h1234_0000);
      issue(32'h0022_0020); wait_idle();
      issue(32'h8C00_0000); wait_idle();
      issue(32'h0022_182B); wait_idle();

      // Reset while the instruction sits in EXEC: nothing may retire.
      issue(32'h0043_4020);
      @(negedge clk);
      chk("exec_before_rst", 32'(alu_op), 32'b0010);
      rst_n = 1'b0;
      sb_q.delete();
      repeat (3) begin
         @(negedge clk);
         chk("rst_mid_quiet", {29'd0, we, done, illegal}, 0);
         chk("rst_mid_ready", 32'(instr_ready), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_mid_rst", 32'(instr_ready), 1);
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_quiet", {29'd0, we, done, illegal}, 0);
      end

      // Held instr_valid: one retire every four cycles.
      done_cyc.delete();
      instr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         int   n;
         exp_t e;
         n = 0;
         instr = rand_legal();
         while (!instr_ready && n < 20) begin @(negedge clk); n++; end
         if (n >= 20) begin
            checks++; errors++;
            $display("FAIL b2b_timeout: instr_ready low for %0d cycles, expected high", n);
         end
         e = model(instr);
         e.xfer = cyc + 1;
         sb_q.push_back(e);
         @(negedge clk);
      end
      instr_valid = 1'b0;
      wait_idle();
      chk("b2b_retires", 32'(done_cyc.size()), 5);
      for (int i = 1; i < done_cyc.size(); i++)
         chk("b2b_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 4);

      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(rand_instr());
      end
      wait_idle();
      chk("sb_drained", 32'(sb_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
